// File: rtl/fact_sequencer.sv
// Request FIFO and issue/response sequencer for the factorial core.
// Optional watchdog abort of a stuck core: define FACT_SEQ_TIMEOUT_EN.
module fact_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_in,
   input  logic [TAG_W-1:0] req_tag,
   output logic             fact_go,
   output logic [3:0]       fact_in,
   input  logic             fact_done,
   input  logic             fact_error,
   input  logic [31:0]      fact_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_error,
   output logic             rsp_timeout,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
      $error("fact_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       op_mem_q  [DEPTH];
   logic [TAG_W-1:0] tag_mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             req_ready_q;
   logic             push, pop, fifo_empty;
   logic [3:0]       fact_in_q, fact_in_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [31:0]      rsp_result_q, rsp_result_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
   logic             rsp_error_q, rsp_error_d;

`ifdef FACT_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]    wd_q;
   logic             rsp_timeout_q, rsp_timeout_d;
`endif

   // req_ready is a flop, so a pop only re-opens the port one cycle later.
   assign push       = req_valid & req_ready_q;
   assign fifo_empty = (count_q == '0);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         op_mem_q[wr_ptr_q]  <= req_in;
         tag_mem_q[wr_ptr_q] <= req_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         req_ready_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q     <= count_d;
         req_ready_q <= (count_d != FULL_CNT);
      end
   end

   // Operand and tag are latched on IDLE->ISSUE so fact_in is valid with go.
   always_comb begin
      state_d      = state_q;
      pop          = 1'b0;
      fact_in_d    = fact_in_q;
      tag_d        = tag_q;
      rsp_result_d = rsp_result_q;
      rsp_tag_d    = rsp_tag_q;
      rsp_error_d  = rsp_error_q;
`ifdef FACT_SEQ_TIMEOUT_EN
      rsp_timeout_d = rsp_timeout_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fact_in_d = op_mem_q[rd_ptr_q];
               tag_d     = tag_mem_q[rd_ptr_q];
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            pop     = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (fact_done || fact_error) begin
               rsp_result_d = fact_error ? 32'd0 : fact_result;
               rsp_error_d  = fact_error;
               rsp_tag_d    = tag_q;
`ifdef FACT_SEQ_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
`endif
               state_d      = S_RESP;
            end
`ifdef FACT_SEQ_TIMEOUT_EN
            else if (wd_q == CW'(TIMEOUT - 1)) begin
               rsp_result_d  = 32'hFFFF_FFFF;
               rsp_error_d   = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_tag_d     = tag_q;
               state_d       = S_RESP;
            end
`endif
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         fact_in_q    <= '0;
         tag_q        <= '0;
         rsp_result_q <= '0;
         rsp_tag_q    <= '0;
         rsp_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         fact_in_q    <= fact_in_d;
         tag_q        <= tag_d;
         rsp_result_q <= rsp_result_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_error_q  <= rsp_error_d;
      end
   end

`ifdef FACT_SEQ_TIMEOUT_EN
   // Watchdog: cleared on go, counts WAIT cycles; expiry loses to a same-cycle done.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q          <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         rsp_timeout_q <= rsp_timeout_d;
         if (state_q == S_ISSUE)     wd_q <= '0;
         else if (state_q == S_WAIT) wd_q <= wd_q + 1'b1;
      end
   end
   assign rsp_timeout = rsp_timeout_q;
`else
   assign rsp_timeout = 1'b0;
`endif

   assign req_ready  = req_ready_q;
   assign fact_go    = (state_q == S_ISSUE);
   assign fact_in    = fact_in_q;
   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_result = rsp_result_q;
   assign rsp_tag    = rsp_tag_q;
   assign rsp_error  = rsp_error_q;
   assign busy       = (state_q != S_IDLE) | ~fifo_empty;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_fact_sequencer.sv
// Bench for fact_sequencer: behavioural core stub, response scoreboard, vector table
// and hand-written stall / reset / watchdog sequences.
`timescale 1ns/1ps
module tb_fact_sequencer;

   localparam int TAG_W   = 4;
   localparam int TIMEOUT = 64;
   localparam int EW      = 32 + TAG_W + 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_in;
   logic [TAG_W-1:0] req_tag;
   logic             fact_go;
   logic [3:0]       fact_in;
   logic             fact_done;
   logic             fact_error;
   logic [31:0]      fact_result;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_result;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_error;
   logic             rsp_timeout;
   logic             busy;
   logic [1:0]       dbg_state;

   fact_sequencer #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_in(req_in), .req_tag(req_tag),
      .fact_go(fact_go), .fact_in(fact_in), .fact_done(fact_done),
      .fact_error(fact_error), .fact_result(fact_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_tag(rsp_tag), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
      .busy(busy), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   // ---------------- shared state ----------------
   int tests_run    = 0;
   int tests_failed = 0;
   logic [EW-1:0] exp_q[$];

   int  go_count    = 0;
   int  last_go_cyc = 0;
   int  done_cyc    = 0;
   int  push_cyc    = 0;
   bit  core_hang   = 1'b0;
   bit  rand_rdy    = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [EW-1:0] pk(input bit to, input bit er,
                                        input logic [TAG_W-1:0] tag, input logic [31:0] res);
      return {to, er, tag, res};
   endfunction

   function automatic logic [31:0] fact_ref(input logic [3:0] n);
      logic [31:0] r;
      r = 32'd1;
      for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
      return r;
   endfunction

   // ---------------- core stub (drives on negedge) ----------------
   initial begin
      bit         core_busy;
      int         core_lat;
      logic [3:0] core_op;
      core_busy   = 1'b0;
      core_lat    = 0;
      core_op     = '0;
      fact_done   = 1'b0;
      fact_error  = 1'b0;
      fact_result = '0;
      forever begin
         @(negedge clk);
         fact_done   = 1'b0;
         fact_error  = 1'b0;
         fact_result = '0;
         if (fact_go) begin
            go_count++;
            last_go_cyc = cyc;
         end
         if (rst) begin
            core_busy = 1'b0;
         end else if (core_busy) begin
            if (core_lat == 0) begin
               core_busy = 1'b0;
               done_cyc  = cyc;
               if (core_op > 4'd12) begin
                  fact_error  = 1'b1;
                  fact_done   = 1'($urandom_range(0, 1));
                  fact_result = $urandom;
               end else begin
                  fact_done   = 1'b1;
                  fact_result = fact_ref(core_op);
               end
            end else begin
               core_lat--;
            end
         end else if (fact_go && !core_hang) begin
            core_op   = fact_in;
            core_busy = 1'b1;
            core_lat  = $urandom_range(0, 3);
         end
      end
   end

   // ---------------- random consumer backpressure ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- response scoreboard (samples on negedge) ----------------
   initial begin
      logic [EW-1:0] cur, snap, exp;
      bit held, prev_v;
      held   = 1'b0;
      prev_v = 1'b0;
      snap   = '0;
      forever begin
         @(negedge clk);
         if (rsp_valid && !prev_v && !core_hang)
            check("rsp_latency", 64'(cyc), 64'(done_cyc + 1));
         prev_v = rsp_valid;
         if (rsp_valid) begin
            cur = {rsp_timeout, rsp_error, rsp_tag, rsp_result};
            if (held) check("rsp_stable", 64'(cur), 64'(snap));
            if (rsp_ready) begin
               tests_run++;
               if (exp_q.size() == 0) begin
                  tests_failed++;
                  $display("FAIL rsp_unexpected: got %0h expected no response", cur);
               end else begin
                  exp = exp_q.pop_front();
                  if (cur !== exp) begin
                     tests_failed++;
                     $display("FAIL rsp_data: got %0h expected %0h", cur, exp);
                  end
               end
               held = 1'b0;
            end else begin
               snap = cur;
               held = 1'b1;
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push(input logic [3:0] op, input logic [TAG_W-1:0] tag, input logic [EW-1:0] exp);
      int n;
      n         = 0;
      req_valid = 1'b1;
      req_in    = op;
      req_tag   = tag;
      while (!req_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!req_ready) begin
         tests_run++;
         tests_failed++;
         $display("FAIL push_ready: got req_ready=0 expected 1 within 200 cycles");
      end else begin
         push_cyc = cyc;
         exp_q.push_back(exp);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0 || busy) begin
         tests_run++;
         tests_failed++;
         $display("FAIL %s: got %0d responses outstanding busy=%0b expected drained",
                  name, exp_q.size(), busy);
         exp_q.delete();
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] out_vec();
      return 64'({req_ready, fact_go, fact_in, rsp_valid, rsp_result, rsp_tag,
                  rsp_error, rsp_timeout, busy});
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0]       op;
      logic [TAG_W-1:0] tag;
      logic [31:0]      res;
      logic             err;
   } vec_t;

   vec_t vecs[8];

   // ---------------- main sequence ----------------
   initial begin
      int g0, pc, acc, n;
      logic [3:0] op;

      vecs[0] = '{4'd5,  4'd3, 32'd120,        1'b0};
      vecs[1] = '{4'd12, 4'd1, 32'h1C8C_FC00,  1'b0};
      vecs[2] = '{4'd0,  4'd2, 32'd1,          1'b0};
      vecs[3] = '{4'd1,  4'd4, 32'd1,          1'b0};
      vecs[4] = '{4'd13, 4'd7, 32'd0,          1'b1};
      vecs[5] = '{4'd7,  4'd8, 32'd5040,       1'b0};
      vecs[6] = '{4'd15, 4'd9, 32'd0,          1'b1};
      vecs[7] = '{4'd10, 4'hF, 32'd3628800,    1'b0};

      rst       = 1'b1;
      req_valid = 1'b0;
      req_in    = '0;
      req_tag   = '0;
      rsp_ready = 1'b1;

      // reset state
      cycles(3);
      check("reset_outputs", out_vec(), 64'd0);
      rst = 1'b0;
      check("req_ready_first_cycle", 64'(req_ready), 64'd0);
      cycles(1);
      check("req_ready_after_reset", 64'(req_ready), 64'd1);
      check("idle_state", 64'(dbg_state), 64'd0);

      // single requests into an idle sequencer
      for (int i = 0; i < 8; i++) begin
         g0 = go_count;
         push(vecs[i].op, vecs[i].tag, pk(1'b0, vecs[i].err, vecs[i].tag, vecs[i].res));
         pc = push_cyc;
         wait_drain("vec_drain");
         check("go_latency", 64'(last_go_cyc - pc), 64'd2);
         check("go_pulses", 64'(go_count - g0), 64'd1);
      end

      // stalled consumer: 1 in flight + 4 queued, then release in order
      rsp_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         req_valid = 1'b1;
         req_in    = 4'(i + 2);
         req_tag   = 4'(i);
         if (req_ready) begin
            acc++;
            exp_q.push_back(pk(1'b0, 1'b0, 4'(i), fact_ref(4'(i + 2))));
         end
         cycles(1);
      end
      req_valid = 1'b0;
      check("stall_accepted", 64'(acc), 64'd5);
      check("stall_full_ready", 64'(req_ready), 64'd0);
      cycles(20);
      check("stall_resp_state", 64'(dbg_state), 64'd3);
      check("stall_still_full", 64'(req_ready), 64'd0);
      rsp_ready = 1'b1;
      wait_drain("stall_drain");

      // random ops under random backpressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         op = 4'($urandom_range(0, 15));
         push(op, 4'(i), pk(1'b0, op > 4'd12, 4'(i), (op > 4'd12) ? 32'd0 : fact_ref(op)));
      end
      rand_rdy  = 1'b0;
      rsp_ready = 1'b1;
      wait_drain("random_drain");

      // reset during WAIT with two queued
      core_hang = 1'b1;
      push(4'd4, 4'd1, pk(1'b0, 1'b0, 4'd1, 32'd24));
      push(4'd5, 4'd2, pk(1'b0, 1'b0, 4'd2, 32'd120));
      push(4'd6, 4'd3, pk(1'b0, 1'b0, 4'd3, 32'd720));
      cycles(3);
      check("pre_reset_wait", 64'(dbg_state), 64'd2);
      rst = 1'b1;
      cycles(1);
      check("mid_reset_outputs", out_vec(), 64'd0);
      exp_q.delete();
      rst       = 1'b0;
      core_hang = 1'b0;
      cycles(20);
      check("post_reset_idle", 64'({busy, rsp_valid}), 64'd0);
      push(4'd3, 4'd5, pk(1'b0, 1'b0, 4'd5, 32'd6));
      wait_drain("post_reset_drain");

      // stuck core
      core_hang = 1'b1;
`ifdef FACT_SEQ_TIMEOUT_EN
      push(4'd4, 4'd9, pk(1'b1, 1'b1, 4'd9, 32'hFFFF_FFFF));
      n = 0;
      while (!rsp_valid && n < 200) begin
         cycles(1);
         n++;
      end
      check("timeout_latency", 64'(cyc - last_go_cyc), 64'(TIMEOUT + 1));
      wait_drain("timeout_drain");
`else
      push(4'd4, 4'd9, pk(1'b0, 1'b0, 4'd9, 32'd24));
      n = 0;
      for (int i = 0; i < 150; i++) begin
         if (rsp_valid) n++;
         cycles(1);
      end
      check("no_timeout_valid_cycles", 64'(n), 64'd0);
      check("no_timeout_still_wait", 64'(dbg_state), 64'd2);
      rst = 1'b1;
      cycles(1);
      exp_q.delete();
      rst = 1'b0;
      cycles(2);
`endif
      core_hang = 1'b0;

      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
